// File: rtl/switch_scheduler_if.sv
// Control, configuration and status bundle for switch_scheduler.
// The oneshot signal exists only when SCHED_ONESHOT_EN is defined.
interface switch_scheduler_if;
  logic       start;
  logic       stop;
  logic [6:0] period;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [6:0] cfg_val;
  logic       cfg_en;
  logic       cfg_ack;
  logic [3:0] fire;
  logic [6:0] count;
  logic       busy;
  logic       wrap;
`ifdef SCHED_ONESHOT_EN
  logic       oneshot;
`endif

  modport master (
`ifdef SCHED_ONESHOT_EN
    output oneshot,
`endif
    output start, stop, period, cfg_wr, cfg_ch, cfg_val, cfg_en,
    input  cfg_ack, fire, count, busy, wrap
  );

  modport slave (
`ifdef SCHED_ONESHOT_EN
    input  oneshot,
`endif
    input  start, stop, period, cfg_wr, cfg_ch, cfg_val, cfg_en,
    output cfg_ack, fire, count, busy, wrap
  );
endinterface

// File: rtl/switch_scheduler.sv
// Four-channel slot scheduler: a 0..period counter fires per-channel pulses on matching slots.
// Define SCHED_ONESHOT_EN to add the oneshot input (single pass, then back to IDLE).
module switch_scheduler (
  input logic              counter_clk,
  input logic              reset_n,
  switch_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t          state;
  state_t          next_state;
  logic [6:0]      count;
  logic [6:0]      period_q;
  logic [3:0][6:0] shadow_val;
  logic [3:0]      shadow_en;
  logic [3:0][6:0] active_val;
  logic [3:0]      active_en;
  logic [3:0]      fire_q;
  logic            wrap_q;
  logic            ack_q;
  logic            at_end;
  logic            oneshot_hit;

  assign at_end = (state == RUN) && (count == period_q);

`ifdef SCHED_ONESHOT_EN
  assign oneshot_hit = bus.oneshot;
`else
  assign oneshot_hit = 1'b0;
`endif

  always_ff @(posedge counter_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // stop beats start everywhere; a oneshot pass ends on its own wrap edge
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start && !bus.stop) next_state = ARM;
      ARM:  next_state = bus.stop ? IDLE : RUN;
      RUN:  if (bus.stop || (at_end && oneshot_hit)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge counter_clk) begin
    if (!reset_n) begin
      count      <= '0;
      period_q   <= '0;
      shadow_val <= '0;
      shadow_en  <= '0;
      active_val <= '0;
      active_en  <= '0;
      fire_q     <= '0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q  <= bus.cfg_wr;
      fire_q <= '0;
      wrap_q <= 1'b0;
      // the copies below read the pre-write shadow, so a coinciding write waits a period
      if (bus.cfg_wr) begin
        shadow_val[bus.cfg_ch] <= bus.cfg_val;
        shadow_en[bus.cfg_ch]  <= bus.cfg_en;
      end
      case (state)
        ARM: begin
          count <= '0;
          if (!bus.stop) begin
            period_q   <= bus.period;
            active_val <= shadow_val;
            active_en  <= shadow_en;
          end
        end
        RUN: begin
          if (bus.stop) begin
            count <= '0;
          end else begin
            for (int i = 0; i < 4; i++) begin
              fire_q[i] <= active_en[i] && (count == active_val[i]);
            end
            if (at_end) begin
              count      <= '0;
              wrap_q     <= 1'b1;
              active_val <= shadow_val;
              active_en  <= shadow_en;
            end else begin
              count <= count + 7'd1;
            end
          end
        end
        default: count <= '0;
      endcase
    end
  end

  assign bus.cfg_ack = ack_q;
  assign bus.fire    = fire_q;
  assign bus.count   = count;
  assign bus.busy    = (state != IDLE);
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_switch_scheduler.sv
// Self-checking bench for switch_scheduler: directed scenarios plus random traffic vs. a slot model.
// Build with SCHED_ONESHOT_EN defined to also exercise the oneshot pass.
module tb_switch_scheduler;

  logic counter_clk;
  logic reset_n;
  int   checks;
  int   errors;

  switch_scheduler_if bus ();

  switch_scheduler dut (
    .counter_clk(counter_clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  initial counter_clk = 1'b0;
  always #5 counter_clk = ~counter_clk;

  // Reference model: mode 0 idle, 1 armed, 2 running; count advances modulo (period+1)
  int         m_mode;
  int         m_count;
  int         m_period;
  int         s_val [4];
  bit         s_en  [4];
  int         a_val [4];
  bit         a_en  [4];
  logic [3:0] e_fire;
  logic       e_wrap;
  logic       e_ack;
  bit         valid;
  bit         m_oneshot;

  initial valid = 1'b0;

  always @(posedge counter_clk) begin
`ifdef SCHED_ONESHOT_EN
    m_oneshot = bus.oneshot;
`else
    m_oneshot = 1'b0;
`endif
    if (!reset_n) begin
      valid    = 1'b1;
      m_mode   = 0;
      m_count  = 0;
      m_period = 0;
      e_fire   = '0;
      e_wrap   = 1'b0;
      e_ack    = 1'b0;
      for (int i = 0; i < 4; i++) begin
        s_val[i] = 0; s_en[i] = 1'b0; a_val[i] = 0; a_en[i] = 1'b0;
      end
    end else begin
      e_ack  = bus.cfg_wr;
      e_fire = '0;
      e_wrap = 1'b0;
      if (m_mode == 2 && !bus.stop)
        for (int i = 0; i < 4; i++) e_fire[i] = a_en[i] && (m_count == a_val[i]);
      if (m_mode == 0) begin
        if (bus.start && !bus.stop) m_mode = 1;
      end else if (bus.stop) begin
        m_mode  = 0;
        m_count = 0;
      end else if (m_mode == 1) begin
        m_period = int'(bus.period);
        m_count  = 0;
        a_val    = s_val;
        a_en     = s_en;
        m_mode   = 2;
      end else begin
        m_count = (m_count + 1) % (m_period + 1);
        if (m_count == 0) begin
          e_wrap = 1'b1;
          a_val  = s_val;
          a_en   = s_en;
          if (m_oneshot) m_mode = 0;
        end
      end
      if (bus.cfg_wr) begin
        s_val[bus.cfg_ch] = int'(bus.cfg_val);
        s_en[bus.cfg_ch]  = bus.cfg_en;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge counter_clk) begin
    if (valid) begin
      checkOutput("model_fire",  32'(bus.fire),    32'(e_fire));
      checkOutput("model_wrap",  32'(bus.wrap),    32'(e_wrap));
      checkOutput("model_ack",   32'(bus.cfg_ack), 32'(e_ack));
      checkOutput("model_count", 32'(bus.count),   32'(m_count));
      checkOutput("model_busy",  32'(bus.busy),    32'(m_mode != 0));
    end
  end

  task automatic cycle();
    @(posedge counter_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [6:0] per);
    bus.start  = st;
    bus.stop   = sp;
    bus.period = per;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [6:0] val, input logic en);
    bus.cfg_wr  = 1'b1;
    bus.cfg_ch  = ch;
    bus.cfg_val = val;
    bus.cfg_en  = en;
    cycle();
    bus.cfg_wr  = 1'b0;
  endtask

  // kind 0: fire[arg], kind 1: wrap, kind 2: count==arg; ends on the negedge of the hit cycle
  task automatic wait_until(input int kind, input int arg, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 60) begin
      cycle();
      @(negedge counter_clk);
      n++;
      case (kind)
        0: hit = bus.fire[arg];
        1: hit = bus.wrap;
        default: hit = (int'(bus.count) == arg);
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout kind=%0d arg=%0d actual=none required=event", kind, arg);
    end
  endtask

  initial begin
    int         n;
    logic [3:0] seen;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 7'd0);
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_val = '0; bus.cfg_en = 1'b0;
`ifdef SCHED_ONESHOT_EN
    bus.oneshot = 1'b0;
`endif
    cycle(); cycle();
    reset_n = 1'b1;
    @(negedge counter_clk);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    checkOutput("reset_busy",  32'(bus.busy),  32'd0);

    // basic run: ch0 slot 5, period 9
    cycle();
    write_cfg(2'd0, 7'd5, 1'b1);
    @(negedge counter_clk);
    checkOutput("ack_after_write", 32'(bus.cfg_ack), 32'd1);
    cycle();
    applyStimulus(1'b1, 1'b0, 7'd9);
    cycle();
    applyStimulus(1'b0, 1'b0, 7'd9);
    @(negedge counter_clk);
    checkOutput("busy_in_arm", 32'(bus.busy), 32'd1);
    wait_until(0, 0, n);
    checkOutput("fire0_latency", 32'(n), 32'd7);
    checkOutput("fire0_count",   32'(bus.count), 32'd6);
    wait_until(0, 0, n);
    checkOutput("fire0_repeat", 32'(n), 32'd10);
    wait_until(1, 0, n);
    checkOutput("wrap_count", 32'(bus.count), 32'd0);

    // channels 1 and 2 share slot 3
    cycle();
    write_cfg(2'd1, 7'd3, 1'b1);
    write_cfg(2'd2, 7'd3, 1'b1);
    wait_until(0, 1, n);
    checkOutput("fire12_same", 32'(bus.fire[2:1]), 32'd3);

    // retarget ch0 mid-period: old slot holds until the wrap
    wait_until(1, 0, n);
    cycle();
    write_cfg(2'd0, 7'd2, 1'b1);
    wait_until(0, 0, n);
    checkOutput("fire0_old_slot", 32'(bus.count), 32'd6);
    wait_until(0, 0, n);
    checkOutput("fire0_new_slot", 32'(bus.count), 32'd3);

    // stop at count 4
    wait_until(2, 4, n);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    @(negedge counter_clk);
    checkOutput("stop_busy",  32'(bus.busy),  32'd0);
    checkOutput("stop_count", 32'(bus.count), 32'd0);
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      @(negedge counter_clk);
      seen |= bus.fire;
    end
    checkOutput("no_fire_after_stop", 32'(seen), 32'd0);
    applyStimulus(1'b1, 1'b1, 7'd9);
    cycle(); cycle(); cycle();
    @(negedge counter_clk);
    checkOutput("start_stop_idle", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 7'd0);

    // period 0
    cycle();
    write_cfg(2'd3, 7'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 7'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 7'd0);
    cycle();
    @(negedge counter_clk);
    checkOutput("p0_first_wrap", 32'(bus.wrap), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(negedge counter_clk);
      checkOutput("p0_wrap",  32'(bus.wrap),    32'd1);
      checkOutput("p0_count", 32'(bus.count),   32'd0);
      checkOutput("p0_fire3", 32'(bus.fire[3]), 32'd1);
    end
    cycle();
    write_cfg(2'd3, 7'd7, 1'b1);
    cycle(); cycle();
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      @(negedge counter_clk);
      seen |= bus.fire;
    end
    checkOutput("p0_val7_silent", 32'(seen), 32'd0);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;

    // reset mid-run with a concurrent write
    applyStimulus(1'b1, 1'b0, 7'd9);
    cycle();
    applyStimulus(1'b0, 1'b0, 7'd9);
    wait_until(2, 6, n);
    reset_n = 1'b0;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_val = 7'd9; bus.cfg_en = 1'b1;
    cycle();
    reset_n = 1'b1;
    bus.cfg_wr = 1'b0;
    @(negedge counter_clk);
    checkOutput("rst_busy",  32'(bus.busy),    32'd0);
    checkOutput("rst_count", 32'(bus.count),   32'd0);
    checkOutput("rst_fire",  32'(bus.fire),    32'd0);
    checkOutput("rst_wrap",  32'(bus.wrap),    32'd0);
    checkOutput("rst_ack",   32'(bus.cfg_ack), 32'd0);
    cycle();
    applyStimulus(1'b1, 1'b0, 7'd9);
    cycle();
    applyStimulus(1'b0, 1'b0, 7'd9);
    seen = '0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      @(negedge counter_clk);
      seen |= bus.fire;
    end
    checkOutput("rst_write_dropped", 32'(seen), 32'd0);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;

`ifdef SCHED_ONESHOT_EN
    write_cfg(2'd0, 7'd2, 1'b1);
    bus.oneshot = 1'b1;
    applyStimulus(1'b1, 1'b0, 7'd4);
    cycle();
    applyStimulus(1'b0, 1'b0, 7'd4);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge counter_clk);
      if (bus.busy) n++;
      cycle();
    end
    checkOutput("oneshot_busy_cycles", 32'(n), 32'd6);
    bus.oneshot = 1'b0;
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom % 250) != 0;
      applyStimulus(($urandom % 8) == 0, ($urandom % 50) == 0,
                    ($urandom % 8 == 0) ? 7'($urandom) : 7'($urandom_range(0, 12)));
      bus.cfg_wr  = ($urandom % 5) == 0;
      bus.cfg_ch  = 2'($urandom);
      bus.cfg_val = 7'($urandom_range(0, 14));
      bus.cfg_en  = ($urandom % 4) != 0;
`ifdef SCHED_ONESHOT_EN
      bus.oneshot = ($urandom % 6) == 0;
`endif
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 7'd0);
    bus.cfg_wr = 1'b0;
    cycle(); cycle();
    @(negedge counter_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_scheduler.md
SWITCH_SCHEDULER -- requirements
Module: switch_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 counter_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the counter_clk rising edge.
REQ-004 start  input  1  level, sampled each cycle; requests a schedule run.
REQ-005 stop  input  1  level, sampled each cycle; aborts a run.
REQ-006 period  input  7  terminal count; counter runs 0..period inclusive; sampled only in ARM.
REQ-007 cfg_wr  input  1  one-cycle write strobe for a channel slot.
REQ-008 cfg_ch  input  2  channel index 0..3 for the write.
REQ-009 cfg_val  input  7  match value for the channel.
REQ-010 cfg_en  input  1  channel enable written with the match value.
REQ-011 cfg_ack  output  1  one-cycle pulse acknowledging each accepted write.
REQ-012 fire  output  4  per-channel one-cycle switch pulse.
REQ-013 count  output  7  current slot counter value.
REQ-014 busy  output  1  high in ARM and RUN.
REQ-015 wrap  output  1  one-cycle pulse when count wraps from period to 0.

Function
REQ-016 The FSM SHALL have three states: IDLE, ARM, RUN.
REQ-017 IDLE -> ARM when start=1 and stop=0; otherwise it SHALL remain in IDLE.
REQ-018 ARM SHALL last exactly one cycle: latch period, load count=0, copy shadow slots to active slots, then go to RUN.
REQ-019 In RUN, count SHALL increment by 1 per cycle; at count==period the next value SHALL be 0 and wrap SHALL pulse in that same next cycle.
REQ-020 With period=0, count SHALL hold 0 and wrap SHALL pulse every RUN cycle after the first.
REQ-021 At every wrap, shadow slots SHALL be copied to active slots, so that configuration changes take effect only on period boundaries.
REQ-022 fire[i] SHALL be registered: it is high in cycle t+1 iff, in cycle t, the state was RUN, active_en[i]=1 and count==active_val[i].
REQ-023 Several channels matching the same count SHALL fire in the same cycle; no arbitration is performed.
REQ-024 A channel with active_val > latched period SHALL never fire.
REQ-025 cfg_wr SHALL be accepted in any state and write {cfg_en, cfg_val} into shadow slot cfg_ch, with cfg_ack high in the following cycle.
REQ-026 A write that coincides with an ARM or wrap copy SHALL NOT reach the active slot until the next copy.
REQ-027 stop=1 in ARM or RUN SHALL return the FSM to IDLE on the next edge, clear count to 0 and suppress all fire pulses from that edge on.
REQ-028 If start and stop are both high, stop SHALL win.
REQ-029 start while in ARM or RUN SHALL be ignored.

Reset
REQ-030 While reset_n=0 at an edge, the block SHALL force state=IDLE, count=0, fire=0, wrap=0, cfg_ack=0, and all shadow and active slots to val=0, en=0.
REQ-031 Reset SHALL take priority over stop, start and cfg_wr, including mid-run; a write present during reset SHALL be discarded and not acknowledged.

Configuration
REQ-032 With SCHED_ONESHOT_EN defined, an extra input oneshot (1 bit) SHALL be present; when oneshot is high at the wrap edge, the FSM SHALL go to IDLE instead of continuing (wrap still pulses, count returns to 0).
REQ-033 Without SCHED_ONESHOT_EN, no oneshot port SHALL exist and RUN SHALL continue until stop or reset.

Verification
REQ-034 Reset, write ch0 val=5 en=1, period=9, start -> cfg_ack one cycle after write; busy next cycle; fire[0] one cycle after count==5, repeating every 10 cycles; wrap after count 9.
REQ-035 Channels 1 and 2 both val=3 en=1 -> fire[1] and fire[2] pulse in the same cycle.
REQ-036 During RUN (period=9, ch0 val=5), write ch0 val=2 -> fire[0] stays at slot 5 until the next wrap, then moves to slot 2.
REQ-037 start and stop held high together in IDLE -> stays IDLE, busy=0; stop asserted at count=4 -> IDLE next cycle, count=0, no further fire.
REQ-038 period=0 -> count stays 0, wrap every RUN cycle; ch3 val=0 en=1 fires every cycle; ch3 val=7 never fires.
REQ-039 reset_n low at count=6 with cfg_wr high -> next cycle IDLE, all outputs 0, no cfg_ack; with SCHED_ONESHOT_EN, oneshot=1 and period=4 -> exactly one pass, then IDLE.
